// File: rtl/logit_pkg.sv
// Shared Q8.8 constants and FSM state codes for the alipi_aprox_logit inverse-sigmoid block.
package logit_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [15:0] Q_ONE     = 16'h0100;
  localparam logic [15:0] Q_HALF    = 16'h0080;
  localparam logic [15:0] Q_QUARTER = 16'h0040;
  localparam logic [15:0] SAT_POS   = 16'h0800;
  localparam logic [15:0] SAT_NEG   = 16'hF800;

endpackage

// File: rtl/alipi_aprox_logit_if.sv
// Valid/ready request and response bundle for alipi_aprox_logit.
interface alipi_aprox_logit_if;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] y_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x_o;
  logic        sat_o;

  modport master (
    output in_valid, y_i, out_ready,
    input  in_ready, out_valid, x_o, sat_o
  );

  modport slave (
    input  in_valid, y_i, out_ready,
    output in_ready, out_valid, x_o, sat_o
  );

endinterface

// File: rtl/logit_norm.sv
// Normalizer step: doubles t until it exceeds a quarter, counting shifts in n.
// LOGIT_FAST_NORM_EN selects a single-step priority-encoder version.
module logit_norm
  import logit_pkg::*;
(
  input  logic [8:0] t,
  input  logic [2:0] n,
  output logic [8:0] t_next,
  output logic [2:0] n_next,
  output logic       done
);

`ifdef LOGIT_FAST_NORM_EN
  logic [2:0] shift;

  // Largest shift whose predecessor is still <= 0x40 is the smallest one that clears it.
  always_comb begin
    shift = 3'd0;
    for (int i = 1; i <= 7; i++) begin
      if (({7'd0, t} << (i - 1)) <= Q_QUARTER) shift = 3'(i);
    end
  end

  assign t_next = t << shift;
  assign n_next = n + shift;
  assign done   = 1'b1;
`else
  assign done   = ({7'd0, t} > Q_QUARTER);
  assign t_next = done ? t : (t << 1);
  assign n_next = done ? n : (n + 3'd1);
`endif

endmodule

// File: rtl/alipi_aprox_logit.sv
// Inverse PWL sigmoid: y (unsigned Q8.8 probability) -> x = logit(y) in signed Q8.8.
// Define LOGIT_FAST_NORM_EN for the single-cycle normalizer (fixed latency 3).
module alipi_aprox_logit
  import logit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alipi_aprox_logit_if.slave   bus
);

  logic [1:0]  state;
  logic [8:0]  t;
  logic [2:0]  n;
  logic        neg;
  logic [15:0] x_q;
  logic        sat_q;
  logic        out_valid_q;

  logic [8:0]  t_next;
  logic [2:0]  n_next;
  logic        norm_done;
  logic [7:0]  f;
  logic [15:0] mag;
  logic [15:0] x_calc;

  logit_norm u_norm (
    .t      (t),
    .n      (n),
    .t_next (t_next),
    .n_next (n_next),
    .done   (norm_done)
  );

  // Normalized t sits in (0x40, 0x80], so the fractional part fits in 8 bits.
  assign f      = 8'((9'(Q_HALF) - t) << 2);
  assign mag    = {5'd0, n, f};
  assign x_calc = neg ? 16'(-mag) : mag;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.x_o       = x_q;
  assign bus.sat_o     = sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      t           <= 9'd0;
      n           <= 3'd0;
      neg         <= 1'b0;
      x_q         <= 16'h0000;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            neg <= (bus.y_i < Q_HALF);
            t   <= (bus.y_i < Q_HALF) ? bus.y_i[8:0] : (9'(Q_ONE) - bus.y_i[8:0]);
            n   <= 3'd0;
            if (bus.y_i == 16'h0000) begin
              x_q   <= SAT_NEG;
              sat_q <= 1'b1;
              state <= DONE;
            end else if (bus.y_i >= Q_ONE) begin
              x_q   <= SAT_POS;
              sat_q <= 1'b1;
              state <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          t <= t_next;
          n <= n_next;
          if (norm_done) state <= CALC;
        end
        CALC: begin
          x_q   <= x_calc;
          sat_q <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          // out_valid lags entry into DONE by one edge; leave only once it has been seen.
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
